// File: rtl/control_sequencer.sv
// Hardwired control unit for the Datapath: fetch T0-T2, then decode IR and run the
// execute steps for ALU3, MUL/DIV, NEG/NOT, NOP and HALT instructions.
module control_sequencer #(
    parameter int OPC_W = 5,
    parameter int NREG  = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            stop,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            MDMuxread,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic            ADD,
    output logic            SUB,
    output logic            MUL,
    output logic            DIV,
    output logic            AND,
    output logic            OR,
    output logic            SHR,
    output logic            SHRA,
    output logic            SHL,
    output logic            ROR,
    output logic            ROL,
    output logic            NEG,
    output logic            NOT,
    output logic            run,
    output logic            instr_done
);

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_SHRA = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(17);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU3, C_MULDIV, C_UNARY, C_HALT
    } cls_t;

    state_t           state, state_nx;
    cls_t             cls;
    logic             last;
    logic [OPC_W-1:0] opc;
    logic [3:0]       ra, rb, rc;
    logic             unused_ir;

    assign opc       = IR[31 -: OPC_W];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    // NOP and every unlisted opcode fall into C_NONE and simply refetch.
    always_comb begin
        cls = C_NONE;
        unique case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = C_ALU3;
            OP_MUL, OP_DIV:                  cls = C_MULDIV;
            OP_NEG, OP_NOT:                  cls = C_UNARY;
            OP_HALT:                         cls = C_HALT;
            default:                         cls = C_NONE;
        endcase
    end

    always_comb begin
        state_nx = state;
        last     = 1'b0;
        unique case (state)
            S_RST:  state_nx = S_T0;
            S_T0:   state_nx = S_T1;
            S_T1:   state_nx = S_T2;
            S_T2: begin
                unique case (cls)
                    C_ALU3, C_MULDIV, C_UNARY: state_nx = S_T3;
                    C_HALT:                    state_nx = S_HALT;
                    default:                   state_nx = S_T0;
                endcase
            end
            S_T3:   state_nx = (cls == C_NONE || cls == C_HALT) ? S_T0 : S_T4;
            S_T4: begin
                if (cls == C_UNARY)                        last = 1'b1;
                else if (cls == C_ALU3 || cls == C_MULDIV) state_nx = S_T5;
                else                                       state_nx = S_T0;
            end
            S_T5: begin
                if (cls == C_ALU3)        last = 1'b1;
                else if (cls == C_MULDIV) state_nx = S_T6;
                else                      state_nx = S_T0;
            end
            S_T6: begin
                if (cls == C_MULDIV) last = 1'b1;
                else                 state_nx = S_T0;
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_RST;
        endcase
        // stop is only honoured at the end of a completed instruction
        if (last) state_nx = stop ? S_HALT : S_T0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_RST;
        else        state <= state_nx;
    end

    assign instr_done = last;

    always_comb begin
        Rin  = '0;
        Rout = '0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin} = '0;
        {Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin}       = '0;
        {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;
        run = (state != S_RST) && (state != S_HALT);
        unique case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                unique case (cls)
                    C_ALU3:   begin Rout = NREG'(1) << rb; Yin = 1'b1; end
                    C_MULDIV: begin Rout = NREG'(1) << ra; Yin = 1'b1; end
                    C_UNARY: begin
                        Rout   = NREG'(1) << rb;
                        Zlowin = 1'b1;
                        NEG    = (opc == OP_NEG);
                        NOT    = (opc == OP_NOT);
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (cls)
                    C_ALU3: begin
                        Rout   = NREG'(1) << rc;
                        Zlowin = 1'b1;
                        ADD    = (opc == OP_ADD);
                        SUB    = (opc == OP_SUB);
                        AND    = (opc == OP_AND);
                        OR     = (opc == OP_OR);
                        ROR    = (opc == OP_ROR);
                        ROL    = (opc == OP_ROL);
                        SHR    = (opc == OP_SHR);
                        SHRA   = (opc == OP_SHRA);
                        SHL    = (opc == OP_SHL);
                    end
                    C_MULDIV: begin
                        Rout    = NREG'(1) << rb;
                        Zlowin  = 1'b1;
                        Zhighin = 1'b1;
                        MUL     = (opc == OP_MUL);
                        DIV     = (opc == OP_DIV);
                    end
                    C_UNARY: begin Zlowout = 1'b1; Rin = NREG'(1) << ra; end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (cls)
                    C_ALU3:   begin Zlowout = 1'b1; Rin = NREG'(1) << ra; end
                    C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                if (cls == C_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, each instruction class, NOP/HALT,
// stop handling and asynchronous clear abort, against hand-derived step values.
module tb_control_sequencer;

    logic        clock, clear, stop;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin;
    logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic run, instr_done;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.OPC_W(5), .NREG(16)) dut (
        .clock(clock), .clear(clear), .IR(IR), .stop(stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .MDMuxread(MDMuxread), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .NEG(NEG), .NOT(NOT), .run(run), .instr_done(instr_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [29:0] ctl;
    logic [61:0] obs;
    assign ctl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin,
                  Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
                  ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                  run, instr_done};
    assign obs = {ctl, Rin, Rout};

    localparam logic [29:0] M_PCOUT = 30'd1 << 29, M_PCIN = 30'd1 << 28, M_INCPC = 30'd1 << 27;
    localparam logic [29:0] M_MARIN = 30'd1 << 26, M_MDRIN = 30'd1 << 25, M_MDROUT = 30'd1 << 24;
    localparam logic [29:0] M_MDMUX = 30'd1 << 23, M_IRIN = 30'd1 << 22, M_YIN = 30'd1 << 21;
    localparam logic [29:0] M_ZLIN = 30'd1 << 20, M_ZHIN = 30'd1 << 19, M_ZLOUT = 30'd1 << 18;
    localparam logic [29:0] M_ZHOUT = 30'd1 << 17, M_HIIN = 30'd1 << 16, M_LOIN = 30'd1 << 15;
    localparam logic [29:0] M_ADD = 30'd1 << 14, M_SUB = 30'd1 << 13, M_MUL = 30'd1 << 12;
    localparam logic [29:0] M_DIV = 30'd1 << 11, M_AND = 30'd1 << 10, M_OR = 30'd1 << 9;
    localparam logic [29:0] M_SHR = 30'd1 << 8, M_SHRA = 30'd1 << 7, M_SHL = 30'd1 << 6;
    localparam logic [29:0] M_ROR = 30'd1 << 5, M_ROL = 30'd1 << 4, M_NEG = 30'd1 << 3;
    localparam logic [29:0] M_NOT = 30'd1 << 2, M_RUN = 30'd1 << 1, M_DONE = 30'd1;

    localparam logic [29:0] E_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam logic [29:0] E_T1 = M_RUN | M_ZLOUT | M_PCIN | M_MDMUX | M_MDRIN;
    localparam logic [29:0] E_T2 = M_RUN | M_MDROUT | M_IRIN;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From T0, advance into T2.
    task automatic to_t2();
        tick();
        tick();
    endtask

    // Pulse clear and come back out in T0.
    task automatic do_clear();
        clear = 1'b0;
        tick();
        clear = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear = 1'b1; stop = 1'b0; IR = 32'h0;
        #2 clear = 1'b0;
        #1;
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL reset_async got %h exp 0", obs); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 62'd0) begin errors++; $display("FAIL reset_hold%0d got %h exp 0", i, obs); end
        end
        clear = 1'b1;
        #1;
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL reset_rst_cycle got %h exp 0", obs); end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL reset_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
        tick();
        checks++;
        if (obs !== {E_T1, 32'h0}) begin errors++; $display("FAIL fetch_t1 got %h exp %h", obs, {E_T1, 32'h0}); end
        tick();
        checks++;
        if (obs !== {E_T2, 32'h0}) begin errors++; $display("FAIL fetch_t2 got %h exp %h", obs, {E_T2, 32'h0}); end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL fetch_refetch got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_neg();
        IR = 32'h8B38_0000;
        to_t2();
        tick();
        checks++;
        if (obs !== {M_RUN | M_NEG | M_ZLIN, 16'h0000, 16'h0080}) begin
            errors++; $display("FAIL neg_t3 got %h exp %h", obs, {M_RUN | M_NEG | M_ZLIN, 16'h0000, 16'h0080});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZLOUT | M_DONE, 16'h0040, 16'h0000}) begin
            errors++; $display("FAIL neg_t4 got %h exp %h", obs, {M_RUN | M_ZLOUT | M_DONE, 16'h0040, 16'h0000});
        end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL neg_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_add();
        IR = 32'h191A_0000;
        to_t2();
        tick();
        checks++;
        if (obs !== {M_RUN | M_YIN, 16'h0000, 16'h0008}) begin
            errors++; $display("FAIL add_t3 got %h exp %h", obs, {M_RUN | M_YIN, 16'h0000, 16'h0008});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ADD | M_ZLIN, 16'h0000, 16'h0010}) begin
            errors++; $display("FAIL add_t4 got %h exp %h", obs, {M_RUN | M_ADD | M_ZLIN, 16'h0000, 16'h0010});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZLOUT | M_DONE, 16'h0004, 16'h0000}) begin
            errors++; $display("FAIL add_t5 got %h exp %h", obs, {M_RUN | M_ZLOUT | M_DONE, 16'h0004, 16'h0000});
        end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL add_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_mul();
        IR = 32'h79A0_0000;
        to_t2();
        tick();
        checks++;
        if (obs !== {M_RUN | M_YIN, 16'h0000, 16'h0008}) begin
            errors++; $display("FAIL mul_t3 got %h exp %h", obs, {M_RUN | M_YIN, 16'h0000, 16'h0008});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_MUL | M_ZLIN | M_ZHIN, 16'h0000, 16'h0010}) begin
            errors++; $display("FAIL mul_t4 got %h exp %h", obs, {M_RUN | M_MUL | M_ZLIN | M_ZHIN, 16'h0000, 16'h0010});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZLOUT | M_LOIN, 32'h0}) begin
            errors++; $display("FAIL mul_t5 got %h exp %h", obs, {M_RUN | M_ZLOUT | M_LOIN, 32'h0});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZHOUT | M_HIIN | M_DONE, 32'h0}) begin
            errors++; $display("FAIL mul_t6 got %h exp %h", obs, {M_RUN | M_ZHOUT | M_HIIN | M_DONE, 32'h0});
        end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL mul_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    // Every ALU3 opcode with Ra=15, Rb=0, Rc=9 to exercise the register-index extremes.
    task automatic test_alu_selects();
        logic [4:0]  op;
        logic [29:0] sel;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin op = 5'd3;  sel = M_ADD;  end
                1: begin op = 5'd4;  sel = M_SUB;  end
                2: begin op = 5'd5;  sel = M_AND;  end
                3: begin op = 5'd6;  sel = M_OR;   end
                4: begin op = 5'd7;  sel = M_ROR;  end
                5: begin op = 5'd8;  sel = M_ROL;  end
                6: begin op = 5'd9;  sel = M_SHR;  end
                7: begin op = 5'd10; sel = M_SHRA; end
                default: begin op = 5'd11; sel = M_SHL; end
            endcase
            IR = {op, 4'd15, 4'd0, 4'd9, 15'd0};
            to_t2();
            tick();
            checks++;
            if (obs !== {M_RUN | M_YIN, 16'h0000, 16'h0001}) begin
                errors++; $display("FAIL alu%0d_t3 got %h exp %h", op, obs, {M_RUN | M_YIN, 16'h0000, 16'h0001});
            end
            tick();
            checks++;
            if (obs !== {M_RUN | sel | M_ZLIN, 16'h0000, 16'h0200}) begin
                errors++; $display("FAIL alu%0d_t4 got %h exp %h", op, obs, {M_RUN | sel | M_ZLIN, 16'h0000, 16'h0200});
            end
            tick();
            checks++;
            if (obs !== {M_RUN | M_ZLOUT | M_DONE, 16'h8000, 16'h0000}) begin
                errors++; $display("FAIL alu%0d_t5 got %h exp %h", op, obs, {M_RUN | M_ZLOUT | M_DONE, 16'h8000, 16'h0000});
            end
            tick();
        end
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL alu_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_not_div();
        IR = {5'b10010, 4'd0, 4'd15, 19'd0};
        to_t2();
        tick();
        checks++;
        if (obs !== {M_RUN | M_NOT | M_ZLIN, 16'h0000, 16'h8000}) begin
            errors++; $display("FAIL not_t3 got %h exp %h", obs, {M_RUN | M_NOT | M_ZLIN, 16'h0000, 16'h8000});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZLOUT | M_DONE, 16'h0001, 16'h0000}) begin
            errors++; $display("FAIL not_t4 got %h exp %h", obs, {M_RUN | M_ZLOUT | M_DONE, 16'h0001, 16'h0000});
        end
        tick();
        IR = {5'b10000, 4'd15, 4'd0, 19'd0};
        to_t2();
        tick();
        checks++;
        if (obs !== {M_RUN | M_YIN, 16'h0000, 16'h8000}) begin
            errors++; $display("FAIL div_t3 got %h exp %h", obs, {M_RUN | M_YIN, 16'h0000, 16'h8000});
        end
        tick();
        checks++;
        if (obs !== {M_RUN | M_DIV | M_ZLIN | M_ZHIN, 16'h0000, 16'h0001}) begin
            errors++; $display("FAIL div_t4 got %h exp %h", obs, {M_RUN | M_DIV | M_ZLIN | M_ZHIN, 16'h0000, 16'h0001});
        end
        tick();
        tick();
        checks++;
        if (obs !== {M_RUN | M_ZHOUT | M_HIIN | M_DONE, 32'h0}) begin
            errors++; $display("FAIL div_t6 got %h exp %h", obs, {M_RUN | M_ZHOUT | M_HIIN | M_DONE, 32'h0});
        end
        tick();
    endtask

    task automatic test_nop();
        IR = {5'b11010, 27'd0};
        to_t2();
        checks++;
        if (obs !== {E_T2, 32'h0}) begin errors++; $display("FAIL nop_t2 got %h exp %h", obs, {E_T2, 32'h0}); end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL nop_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
        IR = {5'b11111, 4'd3, 4'd4, 4'd5, 15'd0};
        to_t2();
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL unlisted_next_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_stop();
        // stop high before the last step must not halt
        IR = 32'h8B38_0000;
        to_t2();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL stop_early_t0 got %h exp %h", obs, {E_T0, 32'h0}); end
        to_t2();
        tick();
        tick();
        stop = 1'b1;
        #1;
        checks++;
        if (instr_done !== 1'b1) begin errors++; $display("FAIL stop_last_done got %b exp 1", instr_done); end
        tick();
        stop = 1'b0;
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL stop_halt got %h exp 0", obs); end
        tick();
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL stop_halt_stays got %h exp 0", obs); end
        do_clear();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL stop_restart got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_halt();
        IR = 32'hD800_0000;
        to_t2();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== 62'd0) begin errors++; $display("FAIL halt_cycle%0d got %h exp 0", i, obs); end
        end
        IR = 32'h0;
        clear = 1'b0;
        tick();
        clear = 1'b1;
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL halt_rst got %h exp 0", obs); end
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL halt_restart got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    task automatic test_clear_abort();
        IR = 32'h191A_0000;
        to_t2();
        tick();
        tick();
        clear = 1'b0;
        #1;
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL abort_immediate got %h exp 0", obs); end
        tick();
        checks++;
        if (obs !== 62'd0) begin errors++; $display("FAIL abort_no_rin got %h exp 0", obs); end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== {E_T0, 32'h0}) begin errors++; $display("FAIL abort_restart got %h exp %h", obs, {E_T0, 32'h0}); end
    endtask

    initial begin
        test_reset();
        test_neg();
        test_add();
        test_mul();
        test_alu_selects();
        test_not_div();
        test_nop();
        test_stop();
        test_halt();
        test_clear_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
